dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the pipelined LEGv8 CPU. It answers the MEM-stage load/store requests (LDUR/STUR) the core issues. It holds DEPTH 64-bit doublewords and serves one request at a time with a programmable access latency. It raises `busy` so the pipeline can freeze its stage registers until the response returns.

## Interface
Parameters:
- `DEPTH`, 128, number of 64-bit words; byte address range 0 .. 8*DEPTH-1.
- `LATENCY`, 2, wait cycles between accept and response; legal range 1..15.

Ports:
- `clk` in 1: single clock, all state changes on rising edge.
- `reset_n` in 1: one clock; reset is synchronous and active-low.
- `req_valid` in 1: request present; requester holds all `req_*` stable until accepted.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data.
- `req_ready` out 1: responder can accept this cycle.
- `resp_valid` out 1: one-cycle response strobe.
- `resp_rdata` out 64: load data; register, updated only by successful loads.
- `resp_error` out 1: request rejected; meaningful only with `resp_valid`, otherwise 0.
- `busy` out 1: stall request to the pipeline.

## Operation
- FSM states: IDLE, WAIT, RESP.
- An accept occurs on an edge where `reset_n`=1, state=IDLE and `req_valid`=1.
  - At accept, capture `req_addr`, `req_wdata` and `req_write`.
  - Word index = `req_addr[63:3]`.
- Error check at accept: `req_addr[2:0]`!=0, or index >= DEPTH.
  - Error path: IDLE→RESP directly with error latched.
  - No memory write; `resp_rdata` unchanged.
- Normal path: IDLE→WAIT, with wait counter loaded to LATENCY-1.
  - WAIT decrements the counter each cycle.
  - When the counter is 0, WAIT→RESP.
  - On that same edge: a store writes `req_wdata` into the array; a load latches `mem[index]` into `resp_rdata`.
- RESP lasts exactly one cycle, then →IDLE unconditionally.
- `req_ready` = (state==IDLE) && `reset_n`.
- `busy` = (state==WAIT) || (state==IDLE && `req_valid`). It is low in RESP so the pipeline advances in the cycle the data is valid.
- `req_valid` outside IDLE is ignored and no request is queued. Requests are strictly serial.
- Reset (`reset_n`=0 at an edge), from any state:
  - state→IDLE, `resp_valid`=0, `resp_error`=0, `resp_rdata`=0, counter=0.
  - An in-flight store not yet committed is dropped.
- Array contents are not affected by reset. They are initialised to all zeros at time zero.
- Store and load share one port, so there are no same-cycle read/write conflicts.

## Timing
- Cycle 0 = accept cycle (`req_valid`&&`req_ready` high).
- Normal request:
  - Cycles 1..LATENCY are WAIT.
  - Cycle LATENCY+1 is RESP: `resp_valid`=1 and `resp_rdata` is valid for a load.
- Error request: RESP in cycle 1.
- Earliest next accept: cycle LATENCY+2 (normal) or cycle 2 (error). Peak throughput is one request per LATENCY+2 cycles.
- `busy` is high in cycles 0..LATENCY (normal) or cycle 0 (error), and low in RESP.
- A store committed at the WAIT→RESP edge is visible to a load accepted at any later edge.
- Reset values of all outputs:
  - While `reset_n`=0: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, `busy`=0.
  - In the first cycle after release: `req_ready`=1.

## Test plan
- Reset: hold `reset_n`=0 for 3 edges with `req_valid`=1 → no accept, all outputs 0. After release, `req_ready`=1 and `busy` follows `req_valid`.
- Store then load (LATENCY=2), both at 0x40:
  - Store 0x0123456789ABCDEF → `resp_valid` in cycle 3 with `resp_error`=0; `busy` high in cycles 0-2.
  - Following load → `resp_rdata`=0x0123456789ABCDEF in its cycle 3.
- Misaligned load at 0x43 → `resp_valid` and `resp_error` in cycle 1. `resp_rdata` keeps its prior value; a later load of 0x40 returns its unchanged contents.
- Out-of-range store at 0x400 (DEPTH=128) → error in cycle 1. Loads of 0x0 and 0x3F8 still return 0.
- Reset mid-operation: store 0xFFFF at 0x80, assert `reset_n`=0 in cycle 1 (WAIT) → no `resp_valid`, and a subsequent load of 0x80 returns 0.
- Back-to-back with `req_valid` held high:
  - Load 0x8 followed by load 0x10 → second accept in cycle 4 (LATENCY=2).
  - Exactly two `resp_valid` pulses, in cycles 3 and 7.
  - `req_ready` low in cycles 1-3.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the LEGv8 MEM stage. It serves one
// LDUR/STUR at a time with a fixed access latency and stalls the pipeline via busy.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             mem_we;
  logic             addr_err;

  // Array starts at all zeros and is deliberately left out of the reset domain.
  logic [63:0] mem_q [DEPTH] = '{default: '0};

  // Reject misaligned doublewords and word indices beyond the array.
  assign addr_err = (req_addr[2:0] != 3'b000) || (req_addr[63:3] >= 61'(DEPTH));

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    write_d = write_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[IDX_W+2:3];
          wdata_d = req_wdata;
          write_d = req_write;
          err_d   = addr_err;
          if (addr_err) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          if (write_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 64'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: memories are not reset; a store still in WAIT when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && reset_n) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == S_IDLE) && reset_n;
  assign resp_valid = (state_q == S_RESP) && reset_n;
  assign resp_error = resp_valid && err_q;
  assign resp_rdata = rdata_q;
  assign busy       = reset_n && ((state_q == S_WAIT) || ((state_q == S_IDLE) && req_valid));

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected responses,
// an independent monitor pops and compares whenever resp_valid is seen.
module tb_dmem_responder;

  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic        busy;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int resp_count = 0;

  typedef struct {
    int          cycle;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic e, input logic [63:0] rd);
    exp_t x;
    x.cycle = c;
    x.err   = e;
    x.rdata = rd;
    sb.push_back(x);
  endtask

  // Monitor: one expected entry per resp_valid pulse, checked for cycle, error and data.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resp_valid) begin
      resp_count++;
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("resp_cycle", 64'(cyc), 64'(e.cycle));
        check("resp_error", {63'd0, resp_error}, {63'd0, e.err});
        check("resp_rdata", resp_rdata, e.rdata);
      end
    end else begin
      check("error_without_valid", {63'd0, resp_error}, 64'd0);
    end
  end

  // Issue one request, check handshake/busy per cycle, and let the monitor check the response.
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic exp_err, input logic [63:0] exp_rdata);
    int acc;
    int lat;
    int n;
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_ready", {63'd0, req_ready}, 64'd1);
    check("busy_accept", {63'd0, busy}, 64'd1);
    acc = cyc;
    lat = exp_err ? 1 : LAT + 1;
    push_exp(acc + lat, exp_err, exp_rdata);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("busy_cycle", {63'd0, busy}, {63'd0, (k < lat)});
      check("ready_low", {63'd0, req_ready}, 64'd0);
    end
    #1;
    check("resp_seen", 64'(sb.size()), 64'd0);
    if (sb.size() != 0) sb.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int acc;
    int base;

    // Reset held for 3 edges with a request pending: nothing may be accepted.
    reset_n   = 1'b0;
    req_valid = 1'b1;
    req_addr  = 64'h40;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", {63'd0, req_ready}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_rdata", resp_rdata, 64'd0);
      check("rst_resp_error", {63'd0, resp_error}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
    end
    req_valid = 1'b0;
    reset_n   = 1'b1;
    #1;
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);
    check("post_rst_busy_lo", {63'd0, busy}, 64'd0);
    req_valid = 1'b1;
    #1;
    check("post_rst_busy_hi", {63'd0, busy}, 64'd1);
    req_valid = 1'b0;

    // Store then load at 0x40.
    do_req(1'b1, 64'h40, 64'h0123456789ABCDEF, 1'b0, 64'd0);
    do_req(1'b0, 64'h40, 64'd0, 1'b0, 64'h0123456789ABCDEF);

    // Misaligned load: error in cycle 1, read data register untouched.
    do_req(1'b0, 64'h43, 64'd0, 1'b1, 64'h0123456789ABCDEF);
    do_req(1'b0, 64'h40, 64'd0, 1'b0, 64'h0123456789ABCDEF);

    // Out-of-range store must not alias into the array.
    do_req(1'b1, 64'h400, 64'hAAAA_5555_AAAA_5555, 1'b1, 64'h0123456789ABCDEF);
    do_req(1'b0, 64'h0, 64'd0, 1'b0, 64'd0);
    do_req(1'b0, 64'h3F8, 64'd0, 1'b0, 64'd0);

    // Reset while a store is in WAIT: no response, store dropped.
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 64'h80;
    req_wdata = 64'hFFFF;
    req_valid = 1'b1;
    #1;
    check("midrst_accept", {63'd0, req_ready}, 64'd1);
    base = resp_count;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("midrst_busy_wait", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy_in_rst", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("midrst_ready", {63'd0, req_ready}, 64'd0);
    check("midrst_rdata", resp_rdata, 64'd0);
    reset_n = 1'b1;
    #1;
    check("midrst_ready_release", {63'd0, req_ready}, 64'd1);
    repeat (4) @(negedge clk);
    #1;
    check("midrst_no_resp", 64'(resp_count - base), 64'd0);
    do_req(1'b0, 64'h80, 64'd0, 1'b0, 64'd0);

    // Back-to-back loads with req_valid held high.
    do_req(1'b1, 64'h8, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'd0);
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = 64'h8;
    req_valid = 1'b1;
    #1;
    check("b2b_first_ready", {63'd0, req_ready}, 64'd1);
    acc  = cyc;
    base = resp_count;
    push_exp(acc + 3, 1'b0, 64'hDEADBEEF_CAFEF00D);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req_addr = 64'h10;
      #1;
      check("b2b_ready_low", {63'd0, req_ready}, 64'd0);
      check("b2b_busy", {63'd0, busy}, {63'd0, (k < 3)});
    end
    @(negedge clk);
    #1;
    check("b2b_second_ready", {63'd0, req_ready}, 64'd1);
    check("b2b_second_cycle", 64'(cyc - acc), 64'd4);
    push_exp(acc + 7, 1'b0, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("b2b_pulses", 64'(resp_count - base), 64'd2);
    check("b2b_drained", 64'(sb.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
